// File: rtl/my_div.sv
// ============================================================================
// Module      : my_div
// Description : Signed fixed-point divider, q = (a * 2^DEC_FORMAT) / b.
//               Sign-magnitude radix-2 restoring division, one quotient bit
//               per cycle, followed by a one-cycle sign/saturate stage.
//               Optional macro MY_DIV_ROUND_EN: round to nearest, ties away
//               from zero, using one extra guard bit and one extra cycle.
//               Without it the quotient is truncated toward zero.
// Ports       : ADC_CLK   - clock, rising edge
//               RESETn    - asynchronous active-low reset
//               in_valid  - operands a/b valid
//               in_ready  - divider idle, accepts operands
//               a, b      - dividend / divisor, signed fixed point
//               q         - registered quotient, signed fixed point
//               out_valid - one-cycle pulse marking a new q
//               sat       - q was saturated (valid with out_valid)
//               div_zero  - b was zero (valid with out_valid)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_div #(
    parameter int DATA_WIDTH = 32,
    parameter int DEC_FORMAT = 16
) (
    input  logic                  ADC_CLK,
    input  logic                  RESETn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  out_valid,
    output logic                  sat,
    output logic                  div_zero
);

`ifdef MY_DIV_ROUND_EN
    localparam int GUARD = 1;
`else
    localparam int GUARD = 0;
`endif

    // Quotient bits produced in CALC (integer + fraction + optional guard).
    localparam int QW = DATA_WIDTH + DEC_FORMAT + GUARD;
    localparam int CW = $clog2(QW + 1);
    localparam logic [CW-1:0] C_LAST = CW'(QW - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [QW-1:0] C_LIM_NEG = {{(QW-1){1'b0}}, 1'b1} << (DATA_WIDTH - 1);
    localparam logic [QW-1:0] C_LIM_POS = C_LIM_NEG - {{(QW-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] C_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] C_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            state_q,  state_d;
    logic [CW-1:0]         cnt_q,    cnt_d;
    logic [QW-1:0]         shreg_q,  shreg_d;   // dividend bits out, quotient bits in
    logic [DATA_WIDTH-1:0] rem_q,    rem_d;
    logic [DATA_WIDTH-1:0] bmag_q,   bmag_d;
    logic                  neg_q,    neg_d;
    logic                  bzero_q,  bzero_d;
    logic [DATA_WIDTH-1:0] q_q,      q_d;
    logic                  ov_q,     ov_d;
    logic                  sat_q,    sat_d;
    logic                  dz_q,     dz_d;

    logic [DATA_WIDTH-1:0] w_amag;
    logic [DATA_WIDTH-1:0] w_bmag;
    logic [DATA_WIDTH:0]   w_trial;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_rem_next;
    logic [QW-1:0]         w_mag;
    logic                  w_over;
    logic [DATA_WIDTH-1:0] w_fix_q;

    // Unsigned magnitudes; the most-negative value maps to 2^(W-1) exactly.
    assign w_amag = a[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - a) : a;
    assign w_bmag = b[DATA_WIDTH-1] ? ({DATA_WIDTH{1'b0}} - b) : b;

    // Restoring step: the partial remainder is always < |b|, so the trial
    // value fits in DATA_WIDTH+1 bits and the difference in DATA_WIDTH bits.
    assign w_trial    = {rem_q, shreg_q[QW-1]};
    assign w_take     = (w_trial >= {1'b0, bmag_q});
    assign w_rem_next = w_take ? (w_trial[DATA_WIDTH-1:0] - bmag_q)
                               : w_trial[DATA_WIDTH-1:0];

`ifdef MY_DIV_ROUND_EN
    // Guard bit set means the fraction is >= 0.5: add it to round up.
    assign w_mag = (shreg_q >> 1) + QW'(shreg_q[0]);
`else
    assign w_mag = shreg_q;
`endif

    // A negative result may reach 2^(W-1); a positive one only 2^(W-1)-1.
    assign w_over = neg_q ? (w_mag > C_LIM_NEG) : (w_mag > C_LIM_POS);

    always_comb begin
        w_fix_q = w_mag[DATA_WIDTH-1:0];
        if (bzero_q || w_over) begin
            w_fix_q = neg_q ? C_MIN : C_MAX;
        end else if (neg_q) begin
            w_fix_q = {DATA_WIDTH{1'b0}} - w_mag[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        bmag_d  = bmag_q;
        neg_d   = neg_q;
        bzero_d = bzero_q;
        q_d     = q_q;
        ov_d    = 1'b0;
        sat_d   = sat_q;
        dz_d    = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = QW'(w_amag) << (QW - DATA_WIDTH);
                    rem_d   = {DATA_WIDTH{1'b0}};
                    bmag_d  = w_bmag;
                    neg_d   = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
                    bzero_d = (b == {DATA_WIDTH{1'b0}});
                    cnt_d   = C_LAST;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                shreg_d = {shreg_q[QW-2:0], w_take};
                rem_d   = w_rem_next;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                q_d     = w_fix_q;
                sat_d   = bzero_q | w_over;
                dz_d    = bzero_q;
                ov_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ADC_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            shreg_q <= {QW{1'b0}};
            rem_q   <= {DATA_WIDTH{1'b0}};
            bmag_q  <= {DATA_WIDTH{1'b0}};
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            q_q     <= {DATA_WIDTH{1'b0}};
            ov_q    <= 1'b0;
            sat_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            bmag_q  <= bmag_d;
            neg_q   <= neg_d;
            bzero_q <= bzero_d;
            q_q     <= q_d;
            ov_q    <= ov_d;
            sat_q   <= sat_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign q         = q_q;
    assign out_valid = ov_q;
    assign sat       = sat_q;
    assign div_zero  = dz_q;

endmodule

`default_nettype wire

// File: doc/my_div.md
MY_DIV -- requirements
Module: my_div

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and quotient width, signed two's complement.
REQ-002 SHALL have parameter DEC_FORMAT, default 16: number of fractional bits in operands and quotient.
REQ-003 SHALL have port ADC_CLK, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-004 SHALL have port RESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operands are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the divider can accept operands.
REQ-007 SHALL have port a, input, DATA_WIDTH bits: dividend, in fixed-point format.
REQ-008 SHALL have port b, input, DATA_WIDTH bits: divisor, in fixed-point format.
REQ-009 SHALL have port q, output, DATA_WIDTH bits: registered quotient, in fixed-point format.
REQ-010 SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking q as valid.
REQ-011 SHALL have port sat, output, 1 bit: q was saturated; valid with out_valid.
REQ-012 SHALL have port div_zero, output, 1 bit: b was zero; valid with out_valid.

Function
REQ-013 SHALL compute q = (a * 2^DEC_FORMAT) / b, truncated toward zero.
REQ-014 SHALL use states IDLE, CALC and FIX; in_ready = 1 only in IDLE.
REQ-015 SHALL complete a transfer on any edge where in_valid and in_ready are both 1, latching a and b.
REQ-016 SHALL latch |a| and |b| as DATA_WIDTH-bit unsigned values and the result sign as a[MSB] XOR b[MSB].
REQ-017 SHALL handle magnitude 2^(DATA_WIDTH-1) exactly (most-negative operand).
REQ-018 SHALL perform CALC as radix-2 restoring division producing one quotient bit per cycle, for DATA_WIDTH+DEC_FORMAT cycles.
REQ-019 SHALL, in FIX (1 cycle), apply the sign, saturate, register q/sat/div_zero, pulse out_valid for 1 cycle and return to IDLE.
REQ-020 SHALL assert out_valid exactly DATA_WIDTH+DEC_FORMAT+2 edges after the accepting edge (50 for defaults).
REQ-021 SHALL accept a new operation in the cycle out_valid is high (back-to-back operation).
REQ-022 SHALL saturate a positive result whose magnitude exceeds 2^(DATA_WIDTH-1)-1 to 0x7FFF_FFFF with sat=1.
REQ-023 SHALL saturate a negative result whose magnitude exceeds 2^(DATA_WIDTH-1) to 0x8000_0000 with sat=1.
REQ-024 SHALL, when b=0, force q=0x7FFF_FFFF if a>=0 or 0x8000_0000 if a<0, with div_zero=1 and sat=1, at normal latency.
REQ-025 SHALL hold q, sat and div_zero between results; they change only on the FIX edge.
REQ-026 SHALL ignore in_valid outside IDLE; held operands are not re-sampled.

Reset
REQ-027 SHALL, while RESETn=0, immediately force state=IDLE, q=0, out_valid=0, sat=0, div_zero=0 and in_ready=1.
REQ-028 SHALL, when reset is asserted mid-CALC or mid-FIX, abort the operation and produce no out_valid after release.
REQ-029 SHALL allow the first accept on the first rising edge after RESETn deasserts.

Configuration
REQ-030 SHALL, with macro MY_DIV_ROUND_EN defined, round to nearest with ties away from zero.
REQ-031 SHALL, with MY_DIV_ROUND_EN defined, compute one extra guard quotient bit in CALC, adding 1 cycle of latency (51 for defaults), with saturation checked after rounding.
REQ-032 SHALL, with MY_DIV_ROUND_EN undefined, truncate toward zero as in REQ-013, with latency per REQ-020.

Verification (defaults, Q16.16)
REQ-033 SHALL cover: a=0x0001_0000, b=0x0002_0000 -> q=0x0000_8000, sat=0, out_valid 50 edges after accept.
REQ-034 SHALL cover: a=0x0002_0000, b=0x0003_0000 -> q=0x0000_AAAA (truncate) or 0x0000_AAAB (MY_DIV_ROUND_EN).
REQ-035 SHALL cover: a=0xFFFE_0000, b=0x0003_0000 -> q=0xFFFF_5556 (truncate) or 0xFFFF_5555 (MY_DIV_ROUND_EN).
REQ-036 SHALL cover: a=0x8000_0000, b=0xFFFF_0000 -> q=0x7FFF_FFFF, sat=1.
REQ-036a SHALL cover: a=0x800A_0000, b=0x0000_0000 -> q=0x8000_0000, div_zero=1, sat=1.
REQ-037 SHALL cover: RESETn pulsed low 10 cycles after accept -> no out_valid, q=0, in_ready=1.
REQ-037a SHALL cover: a second in_valid held through the out_valid cycle -> second result exactly 50 edges later.
